m65c02_rdsel: RTL and testbench
===============================

Name: m65c02_rdsel

Overview:
- Read-side counterpart of the ALU register write-select logic: latches the OAX/OAY/OSY prefix overrides and applies them to register reads.
- Tracks prefix opcodes as they load into the instruction register and holds the override flags for the one instruction that follows.
- Decodes the microcode/instruction read-select fields into a registered one-hot ALU operand source select, with the active register swaps applied.
- The override flags it produces are the OAX/OAY/OSY inputs consumed by the write-select logic.

Parameters:
- OAX_OP, 8'h1B, opcode of the OAX prefix (swap A and X)
- OAY_OP, 8'h3B, opcode of the OAY prefix (swap A and Y)
- OSY_OP, 8'h9B, opcode of the OSY prefix (swap Y and S)

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  synchronous active-high reset
- Rdy  in  1  advance enable; when low, all state and outputs hold
- IR_Ld  in  1  opcode strobe; Opcode valid this cycle
- Opcode  in  8  opcode being loaded into IR
- Done  in  1  current instruction completes this cycle
- ISR  in  1  interrupt/exception entry; discards pending prefixes
- Reg_RE  in  3  microcode register read select
- RSel  in  3  instruction-decoded read select, used when Reg_RE==3'b100
- OAX  out  1  override active: swap A/X
- OAY  out  1  override active: swap A/Y
- OSY  out  1  override active: swap Y/S
- RdSel  out  5  one-hot physical read source {A,X,Y,P,S}; all zero means none
- Pfx_Err  out  1  conflict pulse; present only with the optional feature, else tied 0

Behaviour:
- Reset (Rst==1 at a rising edge, regardless of Rdy):
  - state=IDLE.
  - Latched flags fX, fY, fS = 0.
  - OAX=OAY=OSY=0, RdSel=5'b0, Pfx_Err=0.
- When Rdy==0: nothing changes except under reset.
- Prefix state machine, evaluated only when Rdy==1:
  - IDLE:
    - IR_Ld with a prefix opcode: set its flag, go to PFX.
    - Any other input: stay in IDLE.
  - PFX:
    - IR_Ld with a prefix opcode: merge its flag, stay in PFX.
    - IR_Ld with a non-prefix opcode: go to ACT.
  - ACT:
    - Done without IR_Ld: clear fX, fY, fS; go to IDLE.
    - Done together with IR_Ld of a prefix opcode: clear the old flags, set the new one, go to PFX.
    - Done together with IR_Ld of a non-prefix opcode: clear the flags, go to IDLE.
  - ISR in any state: clear the flags, go to IDLE. ISR has priority over IR_Ld and Done.
- Merge rules (no feature macro):
  - OAX and OAY are mutually exclusive; the last one wins.
  - OSY and OAY are mutually exclusive; the last one wins.
  - OAX and OSY may combine.
  - Repeating the same prefix is idempotent.
- Override outputs:
  - Registered: OAX = fX & (next state==ACT); likewise OAY from fY and OSY from fS.
  - They assert in the cycle after the non-prefix IR_Ld edge.
  - They deassert in the cycle after Done or ISR.
  - In PFX they are 0.
- Logical read decode of Reg_RE:
  - 000 none; 001 X; 010 Y; 011 A; 100 use RSel; 101 S; 110 P; 111 none.
- Logical read decode of RSel (only when Reg_RE==100):
  - 000 none; 001 X; 010 Y; 011 A; 100 none; 101 S; 110 P; 111 P.
- Logical-to-physical mapping, using the current registered OAX/OAY/OSY:
  - A reads X if OAX; reads Y if OAY; else reads A.
  - X reads A if OAX; else reads X.
  - Y reads A if OAY; reads S if OSY; else reads Y.
  - S reads Y if OSY; else reads S.
  - P is never swapped.
- RdSel timing:
  - Registered: RdSel reflects the Reg_RE/RSel sampled at the previous rising edge with Rdy==1. Latency is 1 cycle.
  - RdSel is always one-hot or zero.

Optional Feature:
- Macro: M65C02_PFX_CONFLICT_EN.
- Defined:
  - An incoming prefix that conflicts with an already-latched flag (OAY vs OAX, or OAY vs OSY, in either order) is ignored; the first prefix wins.
  - Pfx_Err pulses high for exactly 1 cycle, in the cycle after that IR_Ld.
  - The state machine proceeds as if the conflicting prefix were a repeat.
- Undefined: last-wins merge as described under Behaviour; Pfx_Err is constant 0.

Test Plan:
- Reset with Rdy=0 -> next cycle state IDLE; OAX=OAY=OSY=0; RdSel=0.
- IR_Ld 8'h1B, then IR_Ld 8'hA5 (non-prefix); hold Reg_RE=011 -> OAX=1 the cycle after the 8'hA5 load; RdSel=5'b01000 (X). Then Done -> OAX=0 next cycle; RdSel=5'b10000.
- IR_Ld 8'h9B, 8'h1B, 8'h85; Reg_RE=100 with RSel=010, then Reg_RE=101 -> OAX=1, OSY=1; RdSel=5'b00001 (S), then 5'b00100 (Y).
- IR_Ld 8'h1B, then ISR=1 together with IR_Ld 8'h3B -> state IDLE; all flags 0; next non-prefix instruction executes unswapped (Reg_RE=011 -> RdSel=5'b10000).
- Rdy=0 for 3 cycles after IR_Ld 8'h3B while Reg_RE toggles -> outputs frozen. With Rdy=1 and IR_Ld 8'h3B then 8'h1B: last-wins gives OAX=1, OAY=0; with M65C02_PFX_CONFLICT_EN gives OAY=1, OAX=0, Pfx_Err pulse of 1 cycle.
- ACT with Done and IR_Ld 8'h3B in the same cycle -> OAX drops to 0 next cycle, state PFX; after next non-prefix IR_Ld, OAY=1 and Reg_RE=010 gives RdSel=5'b10000.

Source files
------------

// File: rtl/m65c02_rdsel.sv
// Register read select for the M65C02 ALU: latches the OAX/OAY/OSY prefix overrides and applies their swaps to operand reads.
// Optional feature macro M65C02_PFX_CONFLICT_EN: the first of two conflicting prefixes wins, and Pfx_Err pulses.
module m65c02_rdsel #(
  parameter logic [7:0] OAX_OP = 8'h1B,
  parameter logic [7:0] OAY_OP = 8'h3B,
  parameter logic [7:0] OSY_OP = 8'h9B
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rdy,
  input  logic       IR_Ld,
  input  logic [7:0] Opcode,
  input  logic       Done,
  input  logic       ISR,
  input  logic [2:0] Reg_RE,
  input  logic [2:0] RSel,
  output logic       OAX,
  output logic       OAY,
  output logic       OSY,
  output logic [4:0] RdSel,
  output logic       Pfx_Err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PFX  = 2'd1;
  localparam logic [1:0] ACT  = 2'd2;

  // One-hot physical sources, ordered {A,X,Y,P,S}
  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_A    = 5'b10000;
  localparam logic [4:0] SEL_X    = 5'b01000;
  localparam logic [4:0] SEL_Y    = 5'b00100;
  localparam logic [4:0] SEL_P    = 5'b00010;
  localparam logic [4:0] SEL_S    = 5'b00001;

  logic [1:0] state, state_nxt;
  logic       f_x, f_y, f_s;
  logic       f_x_nxt, f_y_nxt, f_s_nxt;
  logic       err_nxt;
  logic       merge;
  logic       is_x, is_y, is_s, is_pfx;
  logic [4:0] log_sel, phys_sel;

  assign is_x   = IR_Ld && (Opcode == OAX_OP);
  assign is_y   = IR_Ld && (Opcode == OAY_OP);
  assign is_s   = IR_Ld && (Opcode == OSY_OP);
  assign is_pfx = is_x || is_y || is_s;

  // NOTE: every signal gets a default at the top of the block; otherwise a path that does not assign it infers a latch.
  always_comb begin
    state_nxt = state;
    f_x_nxt   = f_x;
    f_y_nxt   = f_y;
    f_s_nxt   = f_s;
    merge     = 1'b0;
    err_nxt   = 1'b0;

    if (ISR) begin
      state_nxt = IDLE;
      f_x_nxt   = 1'b0;
      f_y_nxt   = 1'b0;
      f_s_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_pfx) begin
            merge     = 1'b1;
            state_nxt = PFX;
          end
        end
        PFX: begin
          if (is_pfx) merge = 1'b1;
          else if (IR_Ld) state_nxt = ACT;
        end
        ACT: begin
          if (Done) begin
            f_x_nxt   = 1'b0;
            f_y_nxt   = 1'b0;
            f_s_nxt   = 1'b0;
            merge     = is_pfx;
            state_nxt = is_pfx ? PFX : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // A new prefix is merged over the base flags chosen above
    if (merge) begin
`ifdef M65C02_PFX_CONFLICT_EN
      if ((is_x && f_y_nxt) || (is_y && (f_x_nxt || f_s_nxt)) || (is_s && f_y_nxt)) begin
        err_nxt = 1'b1;
      end else begin
        if (is_x) f_x_nxt = 1'b1;
        if (is_y) f_y_nxt = 1'b1;
        if (is_s) f_s_nxt = 1'b1;
      end
`else
      if (is_x) begin
        f_x_nxt = 1'b1;
        f_y_nxt = 1'b0;
      end
      if (is_y) begin
        f_y_nxt = 1'b1;
        f_x_nxt = 1'b0;
        f_s_nxt = 1'b0;
      end
      if (is_s) begin
        f_s_nxt = 1'b1;
        f_y_nxt = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    log_sel = SEL_NONE;
    case (Reg_RE)
      3'b001: log_sel = SEL_X;
      3'b010: log_sel = SEL_Y;
      3'b011: log_sel = SEL_A;
      3'b100: begin
        case (RSel)
          3'b001:         log_sel = SEL_X;
          3'b010:         log_sel = SEL_Y;
          3'b011:         log_sel = SEL_A;
          3'b101:         log_sel = SEL_S;
          3'b110, 3'b111: log_sel = SEL_P;
          default:        log_sel = SEL_NONE;
        endcase
      end
      3'b101:  log_sel = SEL_S;
      3'b110:  log_sel = SEL_P;
      default: log_sel = SEL_NONE;
    endcase

    // The swaps use the overrides that are already registered for the instruction in flight
    case (log_sel)
      SEL_A:   phys_sel = OAX ? SEL_X : (OAY ? SEL_Y : SEL_A);
      SEL_X:   phys_sel = OAX ? SEL_A : SEL_X;
      SEL_Y:   phys_sel = OAY ? SEL_A : (OSY ? SEL_S : SEL_Y);
      SEL_S:   phys_sel = OSY ? SEL_Y : SEL_S;
      default: phys_sel = log_sel;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples values from before the edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      f_x     <= 1'b0;
      f_y     <= 1'b0;
      f_s     <= 1'b0;
      OAX     <= 1'b0;
      OAY     <= 1'b0;
      OSY     <= 1'b0;
      RdSel   <= SEL_NONE;
      Pfx_Err <= 1'b0;
    end else if (Rdy) begin
      state   <= state_nxt;
      f_x     <= f_x_nxt;
      f_y     <= f_y_nxt;
      f_s     <= f_s_nxt;
      OAX     <= f_x_nxt && (state_nxt == ACT);
      OAY     <= f_y_nxt && (state_nxt == ACT);
      OSY     <= f_s_nxt && (state_nxt == ACT);
      RdSel   <= phys_sel;
      Pfx_Err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_m65c02_rdsel.sv
// Scoreboard bench for m65c02_rdsel: a prefix-list reference model predicts each cycle's outputs,
// and an independent monitor compares them with the DUT.
module tb_m65c02_rdsel;

  logic       Clk = 1'b0;
  logic       Rst, Rdy, IR_Ld, Done, ISR;
  logic [7:0] Opcode;
  logic [2:0] Reg_RE, RSel;
  logic       OAX, OAY, OSY, Pfx_Err;
  logic [4:0] RdSel;

  m65c02_rdsel dut (
    .Clk(Clk), .Rst(Rst), .Rdy(Rdy), .IR_Ld(IR_Ld), .Opcode(Opcode), .Done(Done),
    .ISR(ISR), .Reg_RE(Reg_RE), .RSel(RSel), .OAX(OAX), .OAY(OAY), .OSY(OSY),
    .RdSel(RdSel), .Pfx_Err(Pfx_Err)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  // Reference model state: the prefixes collected since the last instruction boundary,
  // and whether the instruction they modify is executing.
  logic [7:0] pfx_q[$];
  bit         executing;
  bit         m_oax, m_oay, m_osy, m_err;
  logic [4:0] m_rdsel;

  function automatic bit is_prefix(input logic [7:0] op);
    return (op == 8'h1B) || (op == 8'h3B) || (op == 8'h9B);
  endfunction

  // Replays a list of prefixes under the merge rules. Returns 1 if the last entry was rejected as a conflict.
  function automatic bit resolve(input logic [7:0] q[$], output bit x, output bit y, output bit s);
    bit rejected = 0;
    x = 0; y = 0; s = 0;
    foreach (q[i]) begin
      rejected = 0;
`ifdef M65C02_PFX_CONFLICT_EN
      if ((q[i] == 8'h1B && y) || (q[i] == 8'h3B && (x || s)) || (q[i] == 8'h9B && y)) begin
        rejected = 1;
        continue;
      end
`endif
      case (q[i])
        8'h1B:   begin x = 1; y = 0; end
        8'h3B:   begin y = 1; x = 0; s = 0; end
        8'h9B:   begin s = 1; y = 0; end
        default: ;
      endcase
    end
    return rejected;
  endfunction

  // Logical register index: 0=A 1=X 2=Y 3=P 4=S, -1 none
  function automatic int logical_reg(input logic [2:0] re, input logic [2:0] rs);
    int tbl_re[8] = '{-1, 1, 2, 0, -2, 4, 3, -1};
    int tbl_rs[8] = '{-1, 1, 2, 0, -1, 4, 3, 3};
    return (tbl_re[re] == -2) ? tbl_rs[rs] : tbl_re[re];
  endfunction

  function automatic logic [4:0] physical_sel(input int lr, input bit ox, input bit oy, input bit os);
    int perm[5] = '{0, 1, 2, 3, 4};
    int t;
    if (lr < 0) return 5'b0;
    if (ox) begin t = perm[0]; perm[0] = perm[1]; perm[1] = t; end
    if (oy) begin t = perm[0]; perm[0] = perm[2]; perm[2] = t; end
    if (os) begin t = perm[2]; perm[2] = perm[4]; perm[4] = t; end
    return 5'b10000 >> perm[lr];
  endfunction

  task automatic step(input bit rst, input bit rdy, input bit ir, input logic [7:0] op,
                      input bit done, input bit isr, input logic [2:0] re, input logic [2:0] rs);
    bit x, y, s, rej;
    @(negedge Clk);
    Rst = rst; Rdy = rdy; IR_Ld = ir; Opcode = op; Done = done; ISR = isr; Reg_RE = re; RSel = rs;
    if (rst) begin
      pfx_q.delete();
      executing = 0;
      {m_oax, m_oay, m_osy, m_err} = '0;
      m_rdsel = 5'b0;
    end else if (rdy) begin
      m_rdsel = physical_sel(logical_reg(re, rs), m_oax, m_oay, m_osy);
      m_err = 0;
      if (isr) begin
        pfx_q.delete();
        executing = 0;
      end else if (executing) begin
        if (done) begin
          pfx_q.delete();
          executing = 0;
          if (ir && is_prefix(op)) begin
            pfx_q.push_back(op);
            m_err = resolve(pfx_q, x, y, s);
          end
        end
      end else if (ir) begin
        if (is_prefix(op)) begin
          pfx_q.push_back(op);
          m_err = resolve(pfx_q, x, y, s);
        end else if (pfx_q.size() != 0) begin
          executing = 1;
        end
      end
      rej = resolve(pfx_q, x, y, s);
      m_oax = executing && x;
      m_oay = executing && y;
      m_osy = executing && s;
    end
`ifndef M65C02_PFX_CONFLICT_EN
    m_err = 0;
`endif
    exp_q.push_back({m_oax, m_oay, m_osy, m_rdsel, m_err});
  endtask

  // Monitor: one comparison per rising edge for which an expectation exists
  initial begin
    logic [8:0] exp_v, act_v;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {OAX, OAY, OSY, RdSel, Pfx_Err};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs @%0t: got {OAX,OAY,OSY,RdSel,Pfx_Err}=%b want %b", $time, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    Rst = 0; Rdy = 0; IR_Ld = 0; Opcode = 0; Done = 0; ISR = 0; Reg_RE = 0; RSel = 0;
    // Reset with Rdy low
    step(1, 0, 0, 8'h00, 0, 0, 3'b000, 3'b000);
    // OAX on an A read, then Done
    step(0, 1, 1, 8'h1B, 0, 0, 3'b011, 3'b000);
    step(0, 1, 1, 8'hA5, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 1, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    // OSY + OAX combined, RSel-driven Y read, then S read
    step(0, 1, 1, 8'h9B, 0, 0, 3'b000, 3'b000);
    step(0, 1, 1, 8'h1B, 0, 0, 3'b000, 3'b000);
    step(0, 1, 1, 8'h85, 0, 0, 3'b000, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b100, 3'b010);
    step(0, 1, 0, 8'h00, 0, 0, 3'b101, 3'b000);
    step(0, 1, 0, 8'h00, 1, 0, 3'b011, 3'b000);
    // ISR discards a pending prefix and beats a same-cycle prefix load
    step(0, 1, 1, 8'h1B, 0, 0, 3'b000, 3'b000);
    step(0, 1, 1, 8'h3B, 0, 1, 3'b000, 3'b000);
    step(0, 1, 1, 8'hA5, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 1, 0, 3'b011, 3'b000);
    // Rdy low freezes everything, then conflicting prefixes
    step(0, 1, 1, 8'h3B, 0, 0, 3'b001, 3'b000);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h1B, 1, 1, 3'(i + 2), 3'b000);
    step(0, 1, 1, 8'h1B, 0, 0, 3'b011, 3'b000);
    step(0, 1, 1, 8'h42, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    // Done and a new prefix in the same cycle
    step(0, 1, 1, 8'h3B, 1, 0, 3'b011, 3'b000);
    step(0, 1, 1, 8'h77, 0, 0, 3'b010, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b010, 3'b000);
    step(0, 1, 0, 8'h00, 0, 0, 3'b011, 3'b000);
    step(0, 1, 0, 8'h00, 1, 0, 3'b000, 3'b000);

    // Random traffic biased towards prefix opcodes
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] op;
      case ($urandom_range(0, 7))
        0:       op = 8'h1B;
        1:       op = 8'h3B;
        2:       op = 8'h9B;
        default: op = 8'($urandom());
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, op,
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge Clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
